// File: rtl/star_pkg.sv
// -----------------------------------------------------------------------------
// star_pkg
// Shared definitions for the star mechanism sequencer: state encodings,
// motor-bus bit positions, grill/star sensor codes and latched fault codes.
// -----------------------------------------------------------------------------
package star_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_G_OPEN  = 4'd1,
    ST_SETTLE1 = 4'd2,
    ST_S_MOVE  = 4'd3,
    ST_SETTLE2 = 4'd4,
    ST_G_CLOSE = 4'd5,
    ST_DONE    = 4'd6,
    ST_FAULT   = 4'd7
  } state_t;

  // Bit positions on the 4-bit motor command bus
  localparam int MOTOR_G_OPEN  = 3;
  localparam int MOTOR_G_CLOSE = 2;
  localparam int MOTOR_S_HIDE  = 1;
  localparam int MOTOR_S_EXT   = 0;

  // Grill sensor codes
  localparam logic [1:0] GRILL_CLOSED  = 2'b00;
  localparam logic [1:0] GRILL_OPEN    = 2'b01;
  localparam logic [1:0] GRILL_INVALID = 2'b11;

  // Star sensor codes
  localparam logic [1:0] STAR_UP       = 2'b00;
  localparam logic [1:0] STAR_HIDDEN   = 2'b01;
  localparam logic [1:0] STAR_INVALID  = 2'b11;

  typedef enum logic [2:0] {
    FC_NONE           = 3'd0,
    FC_GRILL_OPEN_TO  = 3'd1,
    FC_STAR_TO        = 3'd2,
    FC_GRILL_CLOSE_TO = 3'd3,
    FC_SENSOR         = 3'd4,
    FC_INTERLOCK      = 3'd5,
    FC_STAR_LOST      = 3'd6
  } fault_t;

  // Sensor code the star must report once it has reached the requested end
  function automatic logic [1:0] star_code(input logic hide);
    return hide ? STAR_HIDDEN : STAR_UP;
  endfunction

endpackage

// File: rtl/star_phase_timer.sv
// -----------------------------------------------------------------------------
// star_phase_timer
// Phase/settle counter. Cleared on i_clr, counts while i_en is high and
// saturates once the count reaches i_limit.
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_clr      synchronous clear (takes priority over counting)
//   i_en       count enable
//   i_limit    compare value
//   o_expired  count has reached i_limit
// -----------------------------------------------------------------------------
module star_phase_timer #(
  parameter int CNT_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  assign o_expired = (r_cnt >= i_limit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/star_motion_sequencer.sv
// -----------------------------------------------------------------------------
// star_motion_sequencer
// Supervisory controller for the star mechanism: open grill -> move star ->
// close grill, with settle dwells between phases, per-phase timeouts, a
// grill/star interlock and a latched fault.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cmd_hide, i_cmd_show  sequence requests, sampled in IDLE only
//   i_abort                 stop motion and return to IDLE (not from FAULT)
//   i_fault_clr             release the latched fault
//   i_grill_pos             00 closed, 01 open, 10 moving, 11 invalid
//   i_star_pos              00 up, 01 hidden, 10 moving, 11 invalid
//   o_motor                 [3] grill open [2] grill close [1] star hide
//                           [0] star extend, decoded from state only
//   o_busy                  sequence in progress
//   o_done                  one-cycle completion pulse
//   o_fault, o_fault_code   latched fault and its cause
//   o_state                 current state for debug
//
// Build option
//   STAR_SEQ_RETRY_EN  when defined, the first timeout of a motion phase
//                      dwells with motors off and retries that phase once.
// -----------------------------------------------------------------------------
module star_motion_sequencer
  import star_pkg::*;
#(
  parameter int               CNT_W         = 24,
  parameter logic [CNT_W-1:0] GRILL_TIMEOUT = 24'd10_000_000,
  parameter logic [CNT_W-1:0] STAR_TIMEOUT  = 24'd10_000_000,
  parameter logic [CNT_W-1:0] SETTLE_CYCLES = 24'd1_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_hide,
  input  logic       i_cmd_show,
  input  logic       i_abort,
  input  logic       i_fault_clr,
  input  logic [1:0] i_grill_pos,
  input  logic [1:0] i_star_pos,
  output logic [3:0] o_motor,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fault,
  output logic [2:0] o_fault_code,
  output logic [3:0] o_state
);

  // The counter reads 0 in the first cycle of a state, so a phase that may
  // last N cycles expires when the count reaches N-1.
  localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] GRILL_LIM  = GRILL_TIMEOUT - ONE;
  localparam logic [CNT_W-1:0] STAR_LIM   = STAR_TIMEOUT - ONE;
  localparam logic [CNT_W-1:0] SETTLE_LIM = SETTLE_CYCLES - ONE;

  state_t           r_state, state_nxt;
  logic             r_target, target_nxt;      // 1 = hide, 0 = show
  fault_t           r_fault_code, code_nxt;
  logic             sensor_bad;
  logic             to_hit;
  fault_t           to_code;
  logic             tmr_clr;
  logic             tmr_expired;
  logic [CNT_W-1:0] tmr_limit;
  logic [1:0]       star_goal;

`ifdef STAR_SEQ_RETRY_EN
  logic             r_retry_used, retry_nxt;
  state_t           r_resume, resume_nxt;       // ST_IDLE = no retry pending
`endif

  assign sensor_bad = (i_grill_pos == GRILL_INVALID) || (i_star_pos == STAR_INVALID);
  assign star_goal  = star_code(r_target);

  // Timer: cleared on every state change, limit chosen by current state
  always_comb begin
    tmr_limit = '0;
    case (r_state)
      ST_G_OPEN, ST_G_CLOSE:  tmr_limit = GRILL_LIM;
      ST_S_MOVE:              tmr_limit = STAR_LIM;
      ST_SETTLE1, ST_SETTLE2: tmr_limit = SETTLE_LIM;
      default:                tmr_limit = '0;
    endcase
  end

  assign tmr_clr = (state_nxt != r_state);

  star_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (tmr_clr),
    .i_en      (1'b1),
    .i_limit   (tmr_limit),
    .o_expired (tmr_expired)
  );

  // Next-state logic; priority abort > sensor invalid > interlock > timeout
  always_comb begin
    state_nxt  = r_state;
    target_nxt = r_target;
    code_nxt   = r_fault_code;
    to_hit     = 1'b0;
    to_code    = FC_NONE;
`ifdef STAR_SEQ_RETRY_EN
    retry_nxt  = r_retry_used;
    resume_nxt = r_resume;
`endif

    if (r_state == ST_FAULT) begin
      if (i_fault_clr) begin
        state_nxt = ST_IDLE;
        code_nxt  = FC_NONE;
      end
    end else if (i_abort) begin
      state_nxt = ST_IDLE;
    end else if ((r_state != ST_IDLE) && sensor_bad) begin
      state_nxt = ST_FAULT;
      code_nxt  = FC_SENSOR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Simultaneous hide and show is ambiguous and is ignored
          if (i_cmd_hide != i_cmd_show) begin
            target_nxt = i_cmd_hide;
            if ((i_grill_pos == GRILL_CLOSED) && (i_star_pos == star_code(i_cmd_hide)))
              state_nxt = ST_DONE;
            else
              state_nxt = ST_G_OPEN;
          end
        end
        ST_G_OPEN: begin
          if (tmr_expired) begin
            to_hit  = 1'b1;
            to_code = FC_GRILL_OPEN_TO;
          end else if (i_grill_pos == GRILL_OPEN) begin
            state_nxt = ST_SETTLE1;
`ifdef STAR_SEQ_RETRY_EN
            retry_nxt = 1'b0;
`endif
          end
        end
        ST_SETTLE1: begin
          if (tmr_expired) begin
`ifdef STAR_SEQ_RETRY_EN
            if (r_resume != ST_IDLE) begin
              state_nxt  = r_resume;
              resume_nxt = ST_IDLE;
            end else
`endif
            state_nxt = ST_S_MOVE;
          end
        end
        ST_S_MOVE: begin
          // Star must never move unless the grill reports fully open
          if (i_grill_pos != GRILL_OPEN) begin
            state_nxt = ST_FAULT;
            code_nxt  = FC_INTERLOCK;
          end else if (tmr_expired) begin
            to_hit  = 1'b1;
            to_code = FC_STAR_TO;
          end else if (i_star_pos == star_goal) begin
            state_nxt = ST_SETTLE2;
`ifdef STAR_SEQ_RETRY_EN
            retry_nxt = 1'b0;
`endif
          end
        end
        ST_SETTLE2: begin
          if (tmr_expired) begin
`ifdef STAR_SEQ_RETRY_EN
            if (r_resume != ST_IDLE) begin
              state_nxt  = r_resume;
              resume_nxt = ST_IDLE;
            end else
`endif
            state_nxt = ST_G_CLOSE;
          end
        end
        ST_G_CLOSE: begin
          // Closing onto a star that left its end position would jam it
          if (i_star_pos != star_goal) begin
            state_nxt = ST_FAULT;
            code_nxt  = FC_STAR_LOST;
          end else if (tmr_expired) begin
            to_hit  = 1'b1;
            to_code = FC_GRILL_CLOSE_TO;
          end else if (i_grill_pos == GRILL_CLOSED) begin
            state_nxt = ST_DONE;
`ifdef STAR_SEQ_RETRY_EN
            retry_nxt = 1'b0;
`endif
          end
        end
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end

    if (to_hit) begin
      state_nxt = ST_FAULT;
      code_nxt  = to_code;
`ifdef STAR_SEQ_RETRY_EN
      // First timeout of this phase: dwell motors-off, then rerun the phase
      if (!r_retry_used) begin
        state_nxt  = (r_state == ST_G_OPEN) ? ST_SETTLE1 : ST_SETTLE2;
        code_nxt   = r_fault_code;
        retry_nxt  = 1'b1;
        resume_nxt = r_state;
      end
`endif
    end

`ifdef STAR_SEQ_RETRY_EN
    if ((state_nxt == ST_IDLE) || (state_nxt == ST_FAULT)) begin
      retry_nxt  = 1'b0;
      resume_nxt = ST_IDLE;
    end
`endif
  end

  // State register stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_target     <= 1'b0;
      r_fault_code <= FC_NONE;
    end else begin
      r_state      <= state_nxt;
      r_target     <= target_nxt;
      r_fault_code <= code_nxt;
    end
  end

`ifdef STAR_SEQ_RETRY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retry_used <= 1'b0;
      r_resume     <= ST_IDLE;
    end else begin
      r_retry_used <= retry_nxt;
      r_resume     <= resume_nxt;
    end
  end
`endif

  // Output decode from registered state only
  always_comb begin
    o_motor = 4'b0000;
    case (r_state)
      ST_G_OPEN:  o_motor[MOTOR_G_OPEN]  = 1'b1;
      ST_G_CLOSE: o_motor[MOTOR_G_CLOSE] = 1'b1;
      ST_S_MOVE: begin
        if (r_target) o_motor[MOTOR_S_HIDE] = 1'b1;
        else          o_motor[MOTOR_S_EXT]  = 1'b1;
      end
      default:    o_motor = 4'b0000;
    endcase
  end

  assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_FAULT);
  assign o_done       = (r_state == ST_DONE);
  assign o_fault      = (r_state == ST_FAULT);
  assign o_fault_code = r_fault_code;
  assign o_state      = r_state;

endmodule

// File: tb/tb_star_motion_sequencer.sv
// -----------------------------------------------------------------------------
// tb_star_motion_sequencer
// Directed sequence with randomized mechanism travel times. A simple plant
// model moves the grill/star sensors in response to the motor bus; expected
// phase lengths follow from travel time, timeout and settle budgets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_star_motion_sequencer;

  localparam int GT = 60;   // grill timeout budget (cycles)
  localparam int ST = 50;   // star timeout budget (cycles)
  localparam int SC = 8;    // settle dwell (cycles)

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_cmd_hide, i_cmd_show, i_abort, i_fault_clr;
  logic [1:0] i_grill_pos, i_star_pos;
  logic [3:0] o_motor;
  logic       o_busy, o_done, o_fault;
  logic [2:0] o_fault_code;
  logic [3:0] o_state;

  int vectors = 0;
  int miscompares = 0;

  // plant model state
  int g_cnt = 0, s_cnt = 0;
  int g_delay_open = 1, g_delay_close = 1, s_delay = 1;
  bit g_stuck = 0, s_stuck = 0;
  bit g_force_en = 0;
  logic [1:0] g_force_val = 2'b00;

  always #5 i_clk = ~i_clk;

  star_motion_sequencer #(
    .CNT_W         (24),
    .GRILL_TIMEOUT (24'd60),
    .STAR_TIMEOUT  (24'd50),
    .SETTLE_CYCLES (24'd8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_cmd_hide   (i_cmd_hide),
    .i_cmd_show   (i_cmd_show),
    .i_abort      (i_abort),
    .i_fault_clr  (i_fault_clr),
    .i_grill_pos  (i_grill_pos),
    .i_star_pos   (i_star_pos),
    .o_motor      (o_motor),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_fault      (o_fault),
    .o_fault_code (o_fault_code),
    .o_state      (o_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mechanism reacts to the motor bus seen in the current cycle
  task automatic plant();
    if (o_motor == 4'b1000) begin
      i_grill_pos = (!g_stuck && g_cnt >= g_delay_open) ? 2'b01 : 2'b10;
      g_cnt++;
    end else if (o_motor == 4'b0100) begin
      i_grill_pos = (!g_stuck && g_cnt >= g_delay_close) ? 2'b00 : 2'b10;
      g_cnt++;
    end else begin
      g_cnt = 0;
    end
    if (o_motor == 4'b0010) begin
      i_star_pos = (!s_stuck && s_cnt >= s_delay) ? 2'b01 : 2'b10;
      s_cnt++;
    end else if (o_motor == 4'b0001) begin
      i_star_pos = (!s_stuck && s_cnt >= s_delay) ? 2'b00 : 2'b10;
      s_cnt++;
    end else begin
      s_cnt = 0;
    end
    if (g_force_en) i_grill_pos = g_force_val;
  endtask

  task automatic step();
    plant();
    @(posedge i_clk);
    #1;
  endtask

  // Number of consecutive cycles the motor bus holds value m
  task automatic measure(input logic [3:0] m, output int n);
    n = 0;
    while (o_motor === m && n < 1000) begin
      n++;
      step();
    end
  endtask

  task automatic start_cmd(input bit hide);
    i_cmd_hide = hide;
    i_cmd_show = !hide;
    step();
    i_cmd_hide = 1'b0;
    i_cmd_show = 1'b0;
  endtask

  task automatic setup(input bit hide);
    g_delay_open  = $urandom_range(1, 20);
    g_delay_close = $urandom_range(1, 20);
    s_delay       = $urandom_range(1, 20);
    i_grill_pos   = 2'b00;
    i_star_pos    = hide ? 2'b00 : 2'b01;
  endtask

  task automatic to_smove(input bit hide);
    int n;
    setup(hide);
    start_cmd(hide);
    check("gopen_motor", o_motor, 4'b1000);
    check("gopen_busy", o_busy, 1'b1);
    measure(4'b1000, n);
    check("gopen_len", n, g_delay_open + 1);
    measure(4'b0000, n);
    check("settle1_len", n, SC);
    check("smove_motor", o_motor, hide ? 4'b0010 : 4'b0001);
  endtask

  task automatic finish_from_smove(input bit hide);
    int n;
    measure(hide ? 4'b0010 : 4'b0001, n);
    check("smove_len", n, s_delay + 1);
    measure(4'b0000, n);
    check("settle2_len", n, SC);
    measure(4'b0100, n);
    check("gclose_len", n, g_delay_close + 1);
    check("done_pulse", o_done, 1'b1);
    check("done_motor", o_motor, 4'b0000);
    step();
    check("done_clear", o_done, 1'b0);
    check("busy_end", o_busy, 1'b0);
  endtask

  task automatic clear_fault();
    i_fault_clr = 1'b1;
    step();
    i_fault_clr = 1'b0;
    check("clr_fault", o_fault, 1'b0);
    check("clr_code", o_fault_code, 3'd0);
    check("clr_busy", o_busy, 1'b0);
  endtask

  initial begin
    int n;
    bit hide;
    i_rst_n = 1'b0;
    i_cmd_hide = 1'b0; i_cmd_show = 1'b0; i_abort = 1'b0; i_fault_clr = 1'b0;
    i_grill_pos = 2'b00; i_star_pos = 2'b00;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_motor", o_motor, 4'b0000);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_fault", o_fault, 1'b0);
    check("rst_code", o_fault_code, 3'd0);
    i_rst_n = 1'b1;
    step();

    // complete sequences, random direction and travel times
    for (int t = 0; t < 4; t++) begin
      hide = bit'($urandom_range(0, 1));
      to_smove(hide);
      finish_from_smove(hide);
    end

    // already at target: straight to DONE, no motion
    i_grill_pos = 2'b00; i_star_pos = 2'b01;
    start_cmd(1'b1);
    check("direct_done", o_done, 1'b1);
    check("direct_motor", o_motor, 4'b0000);
    step();
    check("direct_done_clr", o_done, 1'b0);
    check("direct_idle", o_busy, 1'b0);
    i_star_pos = 2'b00;
    start_cmd(1'b0);
    check("direct_show_done", o_done, 1'b1);
    step();

    // both commands together are ignored
    i_cmd_hide = 1'b1; i_cmd_show = 1'b1;
    step();
    i_cmd_hide = 1'b0; i_cmd_show = 1'b0;
    check("both_busy", o_busy, 1'b0);
    check("both_motor", o_motor, 4'b0000);

    // grill never opens
    i_grill_pos = 2'b00; i_star_pos = 2'b00;
    g_stuck = 1;
    start_cmd(1'b1);
    measure(4'b1000, n);
    check("gopen_to_len", n, GT);
`ifdef STAR_SEQ_RETRY_EN
    measure(4'b0000, n);
    check("gopen_dwell", n, SC);
    measure(4'b1000, n);
    check("gopen_retry_len", n, GT);
`endif
    check("gto_fault", o_fault, 1'b1);
    check("gto_code", o_fault_code, 3'd1);
    check("gto_motor", o_motor, 4'b0000);
    check("gto_busy", o_busy, 1'b0);
    start_cmd(1'b1);
    check("fault_ignores_cmd", o_motor, 4'b0000);
    check("fault_held", o_fault_code, 3'd1);
    clear_fault();
    g_stuck = 0;

    // interlock: grill leaves open during star motion
    to_smove(1'b1);
    g_force_en = 1; g_force_val = 2'b10;
    step();
    g_force_en = 0;
    check("ilk_fault", o_fault, 1'b1);
    check("ilk_code", o_fault_code, 3'd5);
    check("ilk_motor", o_motor, 4'b0000);
    clear_fault();

    // invalid sensor outranks interlock
    to_smove(1'b0);
    g_force_en = 1; g_force_val = 2'b11;
    step();
    g_force_en = 0;
    check("inv_code", o_fault_code, 3'd4);
    check("inv_motor", o_motor, 4'b0000);
    clear_fault();

    // star never arrives
    s_stuck = 1;
    to_smove(1'b1);
    measure(4'b0010, n);
    check("smove_to_len", n, ST);
`ifdef STAR_SEQ_RETRY_EN
    s_stuck = 0;
    measure(4'b0000, n);
    check("smove_dwell", n, SC);
    finish_from_smove(1'b1);
    s_stuck = 1;
    to_smove(1'b1);
    measure(4'b0010, n);
    check("smove_to_len2", n, ST);
    measure(4'b0000, n);
    check("smove_dwell2", n, SC);
    measure(4'b0010, n);
    check("smove_retry_len", n, ST);
`endif
    check("sto_fault", o_fault, 1'b1);
    check("sto_code", o_fault_code, 3'd2);
    s_stuck = 0;
    clear_fault();

    // abort while closing the grill
    to_smove(1'b0);
    measure(4'b0001, n);
    measure(4'b0000, n);
    check("abort_at_gclose", o_motor, 4'b0100);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort_busy", o_busy, 1'b0);
    check("abort_motor", o_motor, 4'b0000);
    check("abort_done", o_done, 1'b0);
    step();
    check("abort_done_later", o_done, 1'b0);

    // asynchronous reset in the middle of a sequence
    setup(1'b1);
    start_cmd(1'b1);
    check("pre_rst_motor", o_motor, 4'b1000);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_motor", o_motor, 4'b0000);
    check("async_rst_busy", o_busy, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step();
    check("post_rst_idle", o_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
